// File: rtl/led_sched.sv
// led_sched: four-requester round-robin LED scheduler with tick-based hold and
// forced-off gap between consecutive grants.
module led_sched #(
    parameter int unsigned PRESCALE = 48000,
    parameter int unsigned DUR_W    = 8,
    parameter int unsigned GAP      = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [3:0]         i_req,
    input  logic [3:0]         i_lvl,
    input  logic [4*DUR_W-1:0] i_dur,
    output logic [3:0]         o_ack,
    output logic [3:0]         o_grant,
    output logic               o_led,
    output logic               o_busy,
    output logic               o_tick
);

    localparam int unsigned PS_W  = 16;
    localparam int unsigned CNT_W = (DUR_W > 8) ? DUR_W : 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [PS_W-1:0]  presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic             lvl_q, lvl_d;
    logic [3:0]       ack_q, ack_d;
    logic [3:0]       grant_q, grant_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;

    logic [1:0]       cand;
    logic [1:0]       win;
    logic [DUR_W-1:0] win_dur;
    logic             win_lvl;

    // Free-running prescaler; the tick is registered on the wrap edge.
    always_comb begin
        if (presc_q == PS_W'(PRESCALE - 1)) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end else begin
            presc_d = presc_q + PS_W'(1);
            tick_d  = 1'b0;
        end
    end

    // Round-robin pick: scan from the farthest slot to the nearest after last
    // so the nearest active requester overwrites the others.
    always_comb begin
        win  = last_q + 2'd1;
        cand = last_q;
        for (int i = 4; i >= 1; i--) begin
            cand = last_q + 2'(i);
            if (i_req[cand]) begin
                win = cand;
            end
        end
        win_dur = i_dur[32'(win) * DUR_W +: DUR_W];
        win_lvl = i_lvl[win];
    end

    // Next-state and registered-output computation for IDLE/HOLD/GAP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        lvl_d   = lvl_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (|i_req) begin
                    state_d = S_HOLD;
                    last_d  = win;
                    lvl_d   = win_lvl;
                    cnt_d   = (win_dur == '0) ? CNT_W'(1) : CNT_W'(win_dur);
                    ack_d   = 4'b0001 << win;
                end
            end
            S_HOLD: begin
                if (tick_q) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            cnt_d   = CNT_W'(GAP);
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (tick_q) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        led_d   = (state_d == S_HOLD) && lvl_d;
        grant_d = (state_d == S_HOLD) ? (4'b0001 << last_d) : 4'b0000;
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd3;
            lvl_q   <= 1'b0;
            ack_q   <= '0;
            grant_q <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            lvl_q   <= lvl_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ack   = ack_q;
    assign o_grant = grant_q;
    assign o_led   = led_q;
    assign o_busy  = busy_q;
    assign o_tick  = tick_q;

endmodule

// File: tb/tb_led_sched.sv
// Scoreboard bench for led_sched: two instances (GAP=2 and GAP=0) driven by
// directed and random request traffic, checked against a tick-arithmetic model.
module tb_led_sched;

    localparam int unsigned P  = 4;
    localparam int unsigned DW = 8;

    typedef struct {
        int g;
        int w;
        int lvl;
        int d;
        int hold;
        int gap;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [3:0]      req_v [2];
    logic [3:0]      lvl_v [2];
    logic [4*DW-1:0] dur_v [2];
    logic [3:0]      ack_w [2];
    logic [3:0]      grant_w [2];
    logic            led_w [2];
    logic            busy_w [2];
    logic            tick_w [2];

    int   edge_n = 0;
    int   total  = 0;
    int   bad    = 0;
    int   gap_p [2] = '{2, 0};
    int   m_last [2];
    int   free_k [2];
    int   last_seen [2];
    bit   rot_mode = 1'b0;
    exp_t q0 [$];
    exp_t q1 [$];

    always #5 clk = ~clk;

    led_sched #(.PRESCALE(P), .DUR_W(DW), .GAP(2)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req_v[0]), .i_lvl(lvl_v[0]),
        .i_dur(dur_v[0]), .o_ack(ack_w[0]), .o_grant(grant_w[0]),
        .o_led(led_w[0]), .o_busy(busy_w[0]), .o_tick(tick_w[0])
    );

    led_sched #(.PRESCALE(P), .DUR_W(DW), .GAP(0)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req_v[1]), .i_lvl(lvl_v[1]),
        .i_dur(dur_v[1]), .o_ack(ack_w[1]), .o_grant(grant_w[1]),
        .o_led(led_w[1]), .o_busy(busy_w[1]), .o_tick(tick_w[1])
    );

    // Rising edges since reset release; edge k is the k-th edge out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    function automatic void chk(string nm, int id, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d want=%0d t=%0t", nm, id, act, exp, $time);
        end
    endfunction

    function automatic void qpush(int id, exp_t e);
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endfunction

    function automatic exp_t qpop(int id);
        if (id == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic int qsize(int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    // Ticks are seen by the scheduler at edges n*P+1 (n>=1); return the edge
    // of the d-th such edge strictly after edge g.
    function automatic int tick_after(int g, int d);
        int n;
        n = (g - 1) / int'(P) + 1;
        return (n + d - 1) * int'(P) + 1;
    endfunction

    // Reference scheduler evaluated with the inputs present at edge edge_n.
    task automatic model_eval(int id);
        exp_t e;
        int   w;
        int   c;
        int   h;
        int   en;
        w = -1;
        if (edge_n >= free_k[id] && req_v[id] != 4'b0000) begin
            for (int i = 1; i <= 4; i++) begin
                c = (m_last[id] + i) % 4;
                if (w < 0 && req_v[id][c]) w = c;
            end
            e.g   = edge_n;
            e.w   = w;
            e.lvl = int'(lvl_v[id][w]);
            e.d   = int'(dur_v[id][w*DW +: DW]);
            if (e.d == 0) e.d = 1;
            h      = tick_after(edge_n, e.d);
            en     = (gap_p[id] > 0) ? tick_after(h, gap_p[id]) : h;
            e.hold = h - edge_n;
            e.gap  = en - h;
            qpush(id, e);
            m_last[id]    = w;
            free_k[id]    = en + 1;
            req_v[id][w]  = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_eval(0);
        model_eval(1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 3000 && !(edge_n >= free_k[0] && edge_n >= free_k[1] &&
                             req_v[0] == 4'b0000 && req_v[1] == 4'b0000)) begin
            step();
            n++;
        end
        chk("drain_timeout", 0, int'(n < 3000), 1);
        step();
        step();
    endtask

    // Monitor: on each acceptance pulse, pop the expectation and measure the
    // hold and gap windows that follow it.
    task automatic monitor(int id);
        exp_t       e;
        int         n;
        int         m;
        int         acks;
        int         herr;
        int         gerr;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (rst_n && ack_w[id] != 4'b0000) begin
                if (qsize(id) == 0) begin
                    chk("unexpected_ack", id, int'(ack_w[id]), 0);
                end else begin
                    e  = qpop(id);
                    oh = 4'b0001 << e.w;
                    chk("grant_edge", id, edge_n, e.g);
                    chk("ack_value", id, int'(ack_w[id]), int'(oh));
                    if (rot_mode)
                        chk("rotation", id, int'(ack_w[id]),
                            int'(4'b0001 << ((last_seen[id] + 1) % 4)));
                    last_seen[id] = e.w;
                    n = 0; acks = 0; herr = 0;
                    while (rst_n && grant_w[id] == oh && n < 2000) begin
                        if (ack_w[id] != 4'b0000) acks++;
                        if (int'(led_w[id]) != e.lvl || !busy_w[id]) herr++;
                        n++;
                        @(negedge clk);
                    end
                    m = 0; gerr = 0;
                    while (rst_n && busy_w[id] && grant_w[id] == 4'b0000 && m < 2000) begin
                        if (led_w[id] || ack_w[id] != 4'b0000) gerr++;
                        m++;
                        @(negedge clk);
                    end
                    if (rst_n) begin
                        chk("hold_len", id, n, e.hold);
                        chk("hold_range", id,
                            int'(n >= (e.d - 1) * int'(P) + 1 && n <= e.d * int'(P)), 1);
                        chk("ack_pulses", id, acks, 1);
                        chk("hold_outputs", id, herr, 0);
                        chk("gap_len", id, m, e.gap);
                        chk("gap_range", id,
                            int'((gap_p[id] == 0) ? (m == 0) :
                                 (m >= (gap_p[id] - 1) * int'(P) + 1 && m <= gap_p[id] * int'(P))), 1);
                        chk("gap_outputs", id, gerr, 0);
                        chk("idle_outputs", id,
                            int'({ack_w[id], grant_w[id], led_w[id], busy_w[id]}), 0);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Tick strobe expected after every P-th edge, independent of the FSM.
    always @(negedge clk) begin
        for (int id = 0; id < 2; id++)
            chk("tick", id, int'(tick_w[id]), int'(edge_n > 0 && edge_n % int'(P) == 0));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int id = 0; id < 2; id++) begin
            req_v[id] = 4'b0000; lvl_v[id] = 4'b0000; dur_v[id] = '0;
            m_last[id] = 3; free_k[id] = 1; last_seen[id] = 3;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int id = 0; id < 2; id++) begin
            chk("rst_ack", id, int'(ack_w[id]), 0);
            chk("rst_grant", id, int'(grant_w[id]), 0);
            chk("rst_led", id, int'(led_w[id]), 0);
            chk("rst_busy", id, int'(busy_w[id]), 0);
            chk("rst_tick", id, int'(tick_w[id]), 0);
        end

        // All four requesting continuously with dur=1: rotation from 0.
        for (int id = 0; id < 2; id++) begin
            req_v[id] = 4'b1111; lvl_v[id] = 4'b1010; dur_v[id] = 32'h01010101;
        end
        rot_mode = 1'b1;
        rst_n = 1'b1;
        repeat (80) begin
            step();
            for (int id = 0; id < 2; id++) req_v[id] = 4'b1111;
        end
        for (int id = 0; id < 2; id++) req_v[id] = 4'b0000;
        wait_idle();
        rot_mode = 1'b0;

        // Single request from requester 0, level 1, three ticks.
        for (int id = 0; id < 2; id++) begin
            req_v[id] = 4'b0001; lvl_v[id] = 4'b0001; dur_v[id] = 32'd3;
        end
        wait_idle();

        // Zero duration from requester 2 behaves as one tick.
        for (int id = 0; id < 2; id++) begin
            req_v[id] = 4'b0100; lvl_v[id] = 4'b0100; dur_v[id] = '0;
        end
        wait_idle();

        // Requests changing during HOLD: only the one active in IDLE wins.
        for (int id = 0; id < 2; id++) begin
            req_v[id] = 4'b1000; lvl_v[id] = 4'b1111; dur_v[id] = 32'h02010101;
        end
        step();
        repeat (2) step();
        for (int id = 0; id < 2; id++) req_v[id] = req_v[id] | 4'b0010;
        repeat (2) step();
        for (int id = 0; id < 2; id++) req_v[id] = (req_v[id] & 4'b1101) | 4'b0100;
        wait_idle();

        // Random traffic with occasional withdrawals.
        repeat (700) begin
            step();
            for (int id = 0; id < 2; id++) begin
                for (int c = 0; c < 4; c++) begin
                    if (!req_v[id][c]) begin
                        if ($urandom_range(0, 5) == 0) begin
                            req_v[id][c] = 1'b1;
                            lvl_v[id][c] = 1'($urandom_range(0, 1));
                            dur_v[id][c*DW +: DW] = ($urandom_range(0, 15) == 0) ?
                                DW'($urandom_range(0, 40)) : DW'($urandom_range(0, 4));
                        end
                    end else if ($urandom_range(0, 29) == 0) begin
                        req_v[id][c] = 1'b0;
                    end
                end
            end
        end
        wait_idle();

        // One-clock reset pulse in the middle of HOLD.
        for (int id = 0; id < 2; id++) begin
            req_v[id] = 4'b0001; lvl_v[id] = 4'b0001; dur_v[id] = 32'd5;
        end
        step();
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        for (int id = 0; id < 2; id++) begin
            chk("midrst_led", id, int'(led_w[id]), 0);
            chk("midrst_busy", id, int'(busy_w[id]), 0);
            chk("midrst_grant", id, int'(grant_w[id]), 0);
            m_last[id] = 3; free_k[id] = 1; last_seen[id] = 3;
            req_v[id] = 4'b1010; lvl_v[id] = 4'b1010; dur_v[id] = 32'h01010101;
        end
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_idle();

        for (int id = 0; id < 2; id++) chk("queue_empty", id, qsize(id), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_sched.md
LED_SCHED -- requirements
Module: led_sched

Interface
REQ-001 SHALL have parameter PRESCALE, default 48000, clocks per tick (1 ms at 48 MHz); legal range 2..65535.
REQ-002 SHALL have parameter DUR_W, default 8, width of each requester's duration field.
REQ-003 SHALL have parameter GAP, default 2, ticks of forced LED-off between consecutive grants; legal range 0..255.
REQ-004 SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit, reset; asynchronous assert, active-low.
REQ-006 SHALL have port i_req, input, 4 bits, per-requester request level; bit k belongs to requester k.
REQ-007 SHALL have port i_lvl, input, 4 bits, per-requester requested LED level.
REQ-008 SHALL have port i_dur, input, 4*DUR_W bits, per-requester hold time in ticks; requester k uses bits [k*DUR_W +: DUR_W].
REQ-009 SHALL have port o_ack, output, 4 bits, one-hot single-clock acceptance pulse.
REQ-010 SHALL have port o_grant, output, 4 bits, one-hot current owner; 0 when no owner.
REQ-011 SHALL have port o_led, output, 1 bit, LED drive level.
REQ-012 SHALL have port o_busy, output, 1 bit, high in HOLD or GAP.
REQ-013 SHALL have port o_tick, output, 1 bit, one-clock strobe every PRESCALE clocks.

Function
REQ-014 SHALL run a free-running prescaler that counts 0..PRESCALE-1 and asserts o_tick for one clock on wrap, independent of FSM state.
REQ-015 SHALL implement FSM states IDLE, HOLD and GAP.
REQ-016 IDLE: SHALL drive o_led=0, o_grant=0 and o_busy=0.
REQ-017 IDLE with any i_req bit high: at that edge SHALL select the winner round-robin, searching from (last+1) mod 4 upward.
REQ-018 Same edge: SHALL latch the winner's i_lvl and i_dur, update last to the winner, and enter HOLD.
REQ-019 Same edge: SHALL register o_ack = one-hot winner for exactly the next clock.
REQ-020 Requests SHALL be sampled only in IDLE; i_req changes during HOLD or GAP SHALL have no effect.
REQ-021 A requester SHALL hold i_req until it sees o_ack; deasserting earlier withdraws the request without side effects.
REQ-022 HOLD: SHALL drive o_led = latched level and o_grant = one-hot winner.
REQ-023 HOLD: the duration counter SHALL be loaded with max(i_dur,1); a latched duration of 0 is treated as 1.
REQ-024 HOLD: the duration counter SHALL decrement on each o_tick.
REQ-025 HOLD SHALL exit on the tick that decrements the counter from 1; HOLD lasts between (d-1)*PRESCALE+1 and d*PRESCALE clocks.
REQ-026 HOLD exit SHALL go to GAP when GAP>0, else directly to IDLE.
REQ-027 GAP: SHALL drive o_led=0 and o_grant=0, load the counter with GAP, and decrement it on each o_tick.
REQ-028 GAP SHALL exit to IDLE on the tick that decrements the counter from 1.
REQ-029 From IDLE, a new grant SHALL occur no earlier than the first clock in IDLE, giving at least one idle clock between grants.
REQ-030 If the entry edge and o_tick coincide, the tick SHALL be ignored for the new counter, which loads its full value.
REQ-031 Duration arithmetic SHALL use DUR_W bits with no wrap; the maximum hold is 2^DUR_W - 1 ticks.
REQ-032 Fairness: with all four requesters continuously requesting, grants SHALL rotate 0,1,2,3,0...

Reset
REQ-033 While i_rst_n=0, the block SHALL hold FSM=IDLE, prescaler=0, counter=0, last=3, latched level/duration=0, and o_ack, o_grant, o_led, o_busy and o_tick all 0.
REQ-034 Reset asserted mid-HOLD or mid-GAP SHALL immediately force o_led=0 and o_grant=0 and discard the pending grant.
REQ-035 After release, o_tick SHALL first pulse PRESCALE clocks after the first rising edge.
REQ-036 After release, the first grant SHALL go to requester 0 when multiple requesters are active.

Verification (PRESCALE=4, DUR_W=8, GAP=2)
REQ-037 Single request: i_req=0001, i_lvl=1, dur=3 -> o_ack=0001 for 1 clock; o_led=1 for 9..12 clocks; then o_led=0 for 5..8 clocks in GAP; then IDLE.
REQ-038 All four request continuously with dur=1 -> o_grant sequence 0001,0010,0100,1000,0001; exactly one o_ack pulse per grant.
REQ-039 dur=0 from requester 2 -> treated as 1 tick: o_led held 1..4 clocks, o_grant=0100.
REQ-040 Reset pulse (i_rst_n low 1 clock) mid-HOLD -> o_led=0 and o_busy=0 asynchronously; the next grant with i_req=1010 goes to requester 1.
REQ-041 GAP=0 build with back-to-back requests -> HOLD to IDLE to HOLD, one IDLE clock between grants with o_led=0.
REQ-042 Requester drops i_req in the same cycle another raises it while in HOLD -> no effect until IDLE; only the requester still active in IDLE is granted.
